// File: rtl/fmap_pingpong_ctrl.sv
// Ping-pong feature-map buffer controller in front of a dual-port RAM.
// Port rw0 writes the incoming stream into one bank while port rw1 drains the
// other completed bank into a 2-entry output FIFO that hides read latency.
module fmap_pingpong_ctrl #(
  parameter int unsigned BITS        = 16,
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned FRAME_WORDS = 8192
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BITS-1:0]       s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BITS-1:0]       m_data,
  output logic                  m_last,
  output logic                  ram_w_ce,
  output logic                  ram_w_we,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [BITS-1:0]       ram_w_wd,
  output logic                  ram_r_ce,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [BITS-1:0]       ram_r_rd,
  output logic [1:0]            bank_full
);

  localparam int unsigned CntW = ADDR_WIDTH - 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_st_e;

  bank_st_e        bank_q [2];
  bank_st_e        bank_d [2];
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic [CntW-1:0] wcnt_q, wcnt_d;
  logic [CntW-1:0] rcnt_q, rcnt_d;

  // Keeps s_ready and read issue low until the first edge after reset release.
  logic run_q;

  logic            inflight_q;
  logic            inflight_last_q;
  logic [BITS-1:0] fifo_data_q [2];
  logic            fifo_last_q [2];
  logic            fifo_wptr_q;
  logic            fifo_rptr_q;
  logic [1:0]      fifo_cnt_q;

  logic       w_open, r_avail;
  logic       w_fire, w_last;
  logic       r_issue, r_last;
  logic       fifo_push, fifo_pop;
  logic [1:0] occ_after_pop;

  // State register: bank states, bank pointers and word counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= StEmpty;
      bank_q[1] <= StEmpty;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      run_q     <= 1'b0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      run_q     <= 1'b1;
    end
  end

  // Next state: writer and reader advance their own bank independently.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wbank_d   = wbank_q;
    rbank_d   = rbank_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    if (w_fire) begin
      if (w_last) begin
        bank_d[wbank_q] = StFull;
        wcnt_d          = '0;
        wbank_d         = ~wbank_q;
      end else begin
        bank_d[wbank_q] = StFilling;
        wcnt_d          = wcnt_q + CntW'(1);
      end
    end
    // Reader only touches FULL/DRAINING banks, writer only EMPTY/FILLING ones,
    // so both updates never land on the same bank in one cycle.
    if (r_issue) begin
      if (r_last) begin
        bank_d[rbank_q] = StEmpty;
        rcnt_d          = '0;
        rbank_d         = ~rbank_q;
      end else begin
        bank_d[rbank_q] = StDraining;
        rcnt_d          = rcnt_q + CntW'(1);
      end
    end
  end

  // Outputs: handshakes, RAM port controls and status.
  always_comb begin
    w_open    = (bank_q[wbank_q] == StEmpty) || (bank_q[wbank_q] == StFilling);
    r_avail   = (bank_q[rbank_q] == StFull) || (bank_q[rbank_q] == StDraining);
    s_ready   = run_q & w_open;
    w_fire    = s_valid & s_ready;
    w_last    = (wcnt_q == LastCnt);
    r_last    = (rcnt_q == LastCnt);
    m_valid   = (fifo_cnt_q != 2'd0);
    fifo_pop  = m_valid & m_ready;
    fifo_push = inflight_q;
    // Credit check counts this cycle's pop so a steady drain runs at 1 word/cycle
    // while FIFO plus in-flight never exceeds two entries.
    occ_after_pop = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, fifo_pop};
    r_issue   = run_q & r_avail & (occ_after_pop < 2'd2);
    m_data    = fifo_data_q[fifo_rptr_q];
    m_last    = m_valid & fifo_last_q[fifo_rptr_q];
    ram_w_ce   = w_fire;
    ram_w_we   = w_fire;
    ram_w_addr = {wbank_q, wcnt_q};
    ram_w_wd   = s_data;
    ram_r_ce   = r_issue;
    ram_r_addr = {rbank_q, rcnt_q};
    bank_full[0] = (bank_q[0] == StFull) || (bank_q[0] == StDraining);
    bank_full[1] = (bank_q[1] == StFull) || (bank_q[1] == StDraining);
  end

  // Read pipeline and output FIFO: RAM data lands one cycle after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q[0]  <= 1'b0;
      fifo_last_q[1]  <= 1'b0;
      fifo_wptr_q     <= 1'b0;
      fifo_rptr_q     <= 1'b0;
      fifo_cnt_q      <= 2'd0;
    end else begin
      inflight_q      <= r_issue;
      inflight_last_q <= r_issue & r_last;
      if (fifo_push) begin
        fifo_data_q[fifo_wptr_q] <= ram_r_rd;
        fifo_last_q[fifo_wptr_q] <= inflight_last_q;
        fifo_wptr_q              <= ~fifo_wptr_q;
      end
      if (fifo_pop) begin
        fifo_rptr_q <= ~fifo_rptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end
  end

endmodule

// File: doc/fmap_pingpong_ctrl.md
Name: fmap_pingpong_ctrl

Overview:
- Ping-pong feature-map buffer controller placed directly in front of the dual-port 16-bit x 16384-word fakeram macro in the CNN datapath.
- Accepts a valid/ready activation stream and writes it into one half of the RAM through port rw0.
- Reads the other, completed half through port rw1 and presents it as a valid/ready stream with frame-end marking.
- Hides the RAM's 1-cycle read latency with an internal 2-entry output FIFO.

Parameters:
- BITS, 16, data word width; equals RAM BITS.
- ADDR_WIDTH, 14, RAM address width; the MSB selects the bank.
- FRAME_WORDS, 8192, words per frame. Legal range is 2..2^(ADDR_WIDTH-1).

Ports:
- clk  in  1  single clock for the block and both RAM ports.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid&s_ready.
- s_data  in  BITS  input word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  BITS  output word.
- m_last  out  1  marks the final word of a frame.
- ram_w_ce  out  1  drives rw0_ce_in.
- ram_w_we  out  1  drives rw0_we_in.
- ram_w_addr  out  ADDR_WIDTH  drives rw0_addr_in.
- ram_w_wd  out  BITS  drives rw0_wd_in.
- ram_r_ce  out  1  drives rw1_ce_in; rw1_we_in is tied 0 at the parent.
- ram_r_addr  out  ADDR_WIDTH  drives rw1_addr_in.
- ram_r_rd  in  BITS  from rw1_rd_out; valid the cycle after ram_r_ce.
- bank_full  out  2  per-bank FULL/DRAINING status.

Behaviour:
- Reset values (async, rst_n=0):
  - Both banks EMPTY; wbank=0, rbank=0; wcnt=0, rcnt=0; FIFO empty; in-flight flag 0.
  - All outputs are 0 during reset: s_ready, m_valid, m_last, ram_*_ce/we, bank_full.
  - s_ready rises the first cycle after reset release.
- Bank state per bank: EMPTY -> FILLING (first write) -> FULL (last write) -> DRAINING (first read issued) -> EMPTY (last read issued).
- Write side:
  - s_ready = (state[wbank] is EMPTY or FILLING).
  - On accept, in the same cycle: ram_w_ce=1, ram_w_we=1, ram_w_addr={wbank, wcnt} zero-extended, ram_w_wd=s_data. This output is combinational from the accept.
  - wcnt increments on each accept. When the accept has wcnt==FRAME_WORDS-1: the bank goes FULL, wcnt goes to 0, and wbank toggles.
- Read side:
  - A read is issued when state[rbank] is FULL or DRAINING, FIFO occupancy + in-flight < 2, and the block is not in reset.
  - Issue drives ram_r_ce=1 and ram_r_addr={rbank, rcnt}. The in-flight flag is set for the next cycle, in which ram_r_rd is pushed into the FIFO together with last=(issued rcnt==FRAME_WORDS-1).
  - When the issue has rcnt==FRAME_WORDS-1: the bank goes EMPTY in that same cycle, rcnt goes to 0, and rbank toggles.
  - With m_ready held high the read side sustains 1 word/cycle.
- Output:
  - m_valid = FIFO not empty; m_data/m_last come from the FIFO head; pop on m_valid&m_ready.
  - Latency from the last write of a frame to the first m_valid is 3 cycles: the FULL transition, then the issue, then the FIFO push.
- Simultaneous events:
  - A bank reaching FULL and the other bank going EMPTY in the same cycle are independent; both apply.
  - A FIFO push and pop in the same cycle leave occupancy unchanged.
  - The writer may start a bank the cycle after its last read was issued. All reads of that bank are already issued, so there is no hazard.
- Both banks FULL: s_ready=0 until the reader releases one bank.
- Reset mid-frame: partial frames are discarded with no RAM access after the reset assertion. After release the stream restarts at bank 0, address 0.
- bank_full[i]=1 while bank i is FULL or DRAINING.

Test Plan:
- FRAME_WORDS=4, behavioural RAM model with 1-cycle registered read, m_ready=1; write 1,2,3,4 back-to-back -> ram_w_addr 0..3. Output 1,2,3,4 on consecutive cycles, first m_valid 3 cycles after the accept of word 4, m_last only on 4.
- FRAME_WORDS=4, m_ready=0, write 8 words 10..17 -> s_ready drops after the 8th accept and bank_full=2'b11. Then m_ready=1 -> 10..17 in order, m_last on 13 and 17, s_ready rises after the read of 13 is issued.
- FRAME_WORDS=4; m_ready toggling 1/0 each cycle plus random s_valid gaps over 20 frames -> exact in-order data, no loss or duplication, FIFO never exceeds 2.
- FRAME_WORDS=4; second frame addressing -> ram_w_addr/ram_r_addr = {1'b1, cnt} i.e. 8192..8195 with ADDR_WIDTH=14.
- FRAME_WORDS=4; assert rst_n low mid-write (after 2 words) and mid-drain -> all outputs 0 immediately. After release, the new frame 20..23 emerges intact from bank 0.
- Default FRAME_WORDS=8192; stream 2 full frames of an incrementing pattern -> bit-exact output, 16384 cycles of drain with m_ready=1.
